// File: rtl/tcp_mon_pkg.sv
// Shared definitions for the TCP packet monitor: cbus register map,
// FSM state encoding and the saturating counter helper.
package tcp_mon_pkg;

   localparam int MON_PKT_CNT    = 0;
   localparam int MON_BEAT_TOTAL = 1;
   localparam int MON_RUNT_CNT   = 2;
   localparam int MON_LAST_SIG   = 3;
   localparam int MON_STATUS     = 4;
   localparam int MON_CTRL       = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } mon_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/tcp_mon_regs.sv
// cbus slave for the packet monitor: edge-detected request, one-cycle ack,
// registered read mux and the counter clear pulse.
module tcp_mon_regs
   import tcp_mon_pkg::*;
#(
   parameter int CBUS_AWID = 16,
   parameter int CBUS_DWID = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cbus_req,
   input  logic                 cbus_rw,
   input  logic [CBUS_AWID-1:0] cbus_addr,
   input  logic [CBUS_DWID-1:0] cbus_wdata,
   output logic                 cbus_ack,
   output logic [CBUS_DWID-1:0] cbus_rdata,
   input  logic [31:0]          i_pkt_cnt,
   input  logic [31:0]          i_beat_total,
   input  logic [31:0]          i_runt_cnt,
   input  logic [31:0]          i_last_sig,
   input  logic [31:0]          i_status,
   output logic                 o_clr
);

   logic                 r_req_d;
   logic                 r_ack;
   logic [CBUS_DWID-1:0] r_rdata;
   logic                 w_rise;
   logic [CBUS_DWID-1:0] w_rd_mux;
   logic                 w_unused;

   assign w_rise   = cbus_req & ~r_req_d;
   assign w_unused = ^cbus_wdata[CBUS_DWID-1:1];

   // Clear acts on the same edge that registers the ack, so it lines up with
   // any EOP/runt update happening in the request cycle and overrides it.
   assign o_clr = w_rise & cbus_rw & (cbus_addr == CBUS_AWID'(MON_CTRL)) & cbus_wdata[0];

   always_comb begin
      w_rd_mux = '0;
      case (cbus_addr)
         CBUS_AWID'(MON_PKT_CNT):    w_rd_mux = CBUS_DWID'(i_pkt_cnt);
         CBUS_AWID'(MON_BEAT_TOTAL): w_rd_mux = CBUS_DWID'(i_beat_total);
         CBUS_AWID'(MON_RUNT_CNT):   w_rd_mux = CBUS_DWID'(i_runt_cnt);
         CBUS_AWID'(MON_LAST_SIG):   w_rd_mux = CBUS_DWID'(i_last_sig);
         CBUS_AWID'(MON_STATUS):     w_rd_mux = CBUS_DWID'(i_status);
         default:                    w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_d <= 1'b0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_req_d <= cbus_req;
         r_ack   <= w_rise;
         if (w_rise && !cbus_rw)
            r_rdata <= w_rd_mux;
      end
   end

   assign cbus_ack   = r_ack;
   assign cbus_rdata = r_rdata;

endmodule

// File: rtl/tcp_pkt_mon.sv
// Packet monitor for the TOE poll generator stream: patterned backpressure,
// beat-count delimiting, packet/beat/runt counters and XOR payload signature.
module tcp_pkt_mon
   import tcp_mon_pkg::*;
#(
   parameter int DAT_WID   = 256,
   parameter int MSG_WID   = 20,
   parameter int CBUS_AWID = 16,
   parameter int CBUS_DWID = 32,
   parameter int DBG_WID   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_pkt_vld,
   output logic                 rx_pkt_rdy,
   input  logic [DAT_WID-1:0]   rx_pkt_dat,
   input  logic [MSG_WID-1:0]   rx_pkt_msg,
   input  logic [31:0]          cfg_pkt_len,
   input  logic [31:0]          cfg_rdy_pat,
   input  logic [31:0]          cfg_timeout,
   input  logic                 cfg_mon_en,
   input  logic                 cbus_req,
   input  logic                 cbus_rw,
   output logic                 cbus_ack,
   input  logic [CBUS_AWID-1:0] cbus_addr,
   input  logic [CBUS_DWID-1:0] cbus_wdata,
   output logic [CBUS_DWID-1:0] cbus_rdata,
   output logic [DBG_WID-1:0]   dbg_sig
);

   function automatic logic [31:0] fold(input logic [DAT_WID-1:0] d);
      logic [31:0] x;
      x = '0;
      for (int i = 0; i < DAT_WID/32; i++)
         x = x ^ d[i*32 +: 32];
      return x;
   endfunction

   mon_state_e   r_state, w_state_nxt;
   logic [4:0]   r_pat_idx;
   logic [31:0]  r_beat_cnt, w_beat_nxt;
   logic [31:0]  r_idle_cnt, w_idle_nxt;
   logic [31:0]  r_sig, w_sig_nxt;
   logic [31:0]  r_pkt_cnt, r_beat_total, r_runt_cnt, r_last_sig;
   logic         r_last_msg0;
   logic [DBG_WID-1:0] r_dbg;
   logic         w_acc, w_eop, w_runt, w_clr;
   logic [31:0]  w_len_eff, w_fold, w_idle_inc, w_status;
   logic         w_unused_msg;

   // rst gates ready combinationally so the source sees no ready while held.
   assign rx_pkt_rdy   = cfg_mon_en & cfg_rdy_pat[r_pat_idx] & ~rst;
   assign w_acc        = rx_pkt_vld & rx_pkt_rdy;
   assign w_len_eff    = (cfg_pkt_len == 32'd0) ? 32'd1 : cfg_pkt_len;
   assign w_fold       = fold(rx_pkt_dat);
   assign w_idle_inc   = sat_inc(r_idle_cnt);
   assign w_unused_msg = ^rx_pkt_msg[MSG_WID-1:1];

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat_cnt;
      w_sig_nxt   = r_sig;
      w_idle_nxt  = r_idle_cnt;
      w_eop       = 1'b0;
      w_runt      = 1'b0;
      if (!cfg_mon_en) begin
         w_state_nxt = ST_IDLE;
         w_idle_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  w_beat_nxt = 32'd1;
                  w_sig_nxt  = w_fold;
                  w_idle_nxt = '0;
                  if (w_len_eff == 32'd1)
                     w_eop = 1'b1;
                  else
                     w_state_nxt = ST_BODY;
               end
            end
            ST_BODY: begin
               if (w_acc) begin
                  w_beat_nxt = r_beat_cnt + 32'd1;
                  w_sig_nxt  = r_sig ^ w_fold;
                  w_idle_nxt = '0;
                  // >= rather than == so a mid-packet length reduction still terminates.
                  if (r_beat_cnt + 32'd1 >= w_len_eff) begin
                     w_eop       = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_idle_nxt = w_idle_inc;
                  if (cfg_timeout != 32'd0 && w_idle_inc == cfg_timeout) begin
                     w_runt      = 1'b1;
                     w_idle_nxt  = '0;
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pat_idx  <= '0;
         r_beat_cnt <= '0;
         r_idle_cnt <= '0;
         r_sig      <= '0;
         r_dbg      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pat_idx  <= cfg_mon_en ? r_pat_idx + 5'd1 : 5'd0;
         r_beat_cnt <= w_beat_nxt;
         r_idle_cnt <= w_idle_nxt;
         r_sig      <= w_sig_nxt;
         r_dbg      <= DBG_WID'({r_state, r_pat_idx, r_beat_cnt[25:0]});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pkt_cnt    <= '0;
         r_beat_total <= '0;
         r_runt_cnt   <= '0;
         r_last_sig   <= '0;
         r_last_msg0  <= 1'b0;
      end else begin
         if (w_eop)
            r_last_msg0 <= rx_pkt_msg[0];
         if (w_clr) begin
            r_pkt_cnt    <= '0;
            r_beat_total <= '0;
            r_runt_cnt   <= '0;
            r_last_sig   <= '0;
         end else begin
            if (w_eop) begin
               r_pkt_cnt  <= sat_inc(r_pkt_cnt);
               r_last_sig <= w_sig_nxt;
            end
            if (w_acc)
               r_beat_total <= sat_inc(r_beat_total);
            if (w_runt)
               r_runt_cnt <= sat_inc(r_runt_cnt);
         end
      end
   end

   assign w_status = {19'd0, r_pat_idx, 6'd0, r_last_msg0, (r_state == ST_BODY)};
   assign dbg_sig  = r_dbg;

   tcp_mon_regs #(
      .CBUS_AWID (CBUS_AWID),
      .CBUS_DWID (CBUS_DWID)
   ) u_regs (
      .clk          (clk),
      .rst          (rst),
      .cbus_req     (cbus_req),
      .cbus_rw      (cbus_rw),
      .cbus_addr    (cbus_addr),
      .cbus_wdata   (cbus_wdata),
      .cbus_ack     (cbus_ack),
      .cbus_rdata   (cbus_rdata),
      .i_pkt_cnt    (r_pkt_cnt),
      .i_beat_total (r_beat_total),
      .i_runt_cnt   (r_runt_cnt),
      .i_last_sig   (r_last_sig),
      .i_status     (w_status),
      .o_clr        (w_clr)
   );

endmodule

// File: tb/tb_tcp_pkt_mon.sv
// Self-checking bench for tcp_pkt_mon: directed scenarios plus random traffic
// compared every cycle against a queue-based packet model.
module tb_tcp_pkt_mon;

   logic         clk = 1'b0;
   logic         rst;
   logic         rx_pkt_vld;
   logic         rx_pkt_rdy;
   logic [255:0] rx_pkt_dat;
   logic [19:0]  rx_pkt_msg;
   logic [31:0]  cfg_pkt_len, cfg_rdy_pat, cfg_timeout;
   logic         cfg_mon_en;
   logic         cbus_req, cbus_rw, cbus_ack;
   logic [15:0]  cbus_addr;
   logic [31:0]  cbus_wdata, cbus_rdata;
   logic [31:0]  dbg_sig;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tcp_pkt_mon dut (
      .clk        (clk),
      .rst        (rst),
      .rx_pkt_vld (rx_pkt_vld),
      .rx_pkt_rdy (rx_pkt_rdy),
      .rx_pkt_dat (rx_pkt_dat),
      .rx_pkt_msg (rx_pkt_msg),
      .cfg_pkt_len(cfg_pkt_len),
      .cfg_rdy_pat(cfg_rdy_pat),
      .cfg_timeout(cfg_timeout),
      .cfg_mon_en (cfg_mon_en),
      .cbus_req   (cbus_req),
      .cbus_rw    (cbus_rw),
      .cbus_ack   (cbus_ack),
      .cbus_addr  (cbus_addr),
      .cbus_wdata (cbus_wdata),
      .cbus_rdata (cbus_rdata),
      .dbg_sig    (dbg_sig)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pkt, m_beats, m_runt, m_last_sig, m_idle, m_rd_exp;
   logic        m_msg0, m_req_d, m_ack_exp;
   int          m_idx;
   logic [31:0] cur[$];

   function automatic logic [31:0] fold_m(input logic [255:0] d);
      logic [31:0] x;
      x = '0;
      for (int i = 0; i < 8; i++) x ^= d[i*32 +: 32];
      return x;
   endfunction

   function automatic logic [31:0] sinc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 1;
   endfunction

   function automatic logic [31:0] m_read(input logic [15:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         16'd0: v = m_pkt;
         16'd1: v = m_beats;
         16'd2: v = m_runt;
         16'd3: v = m_last_sig;
         16'd4: begin
            v[0]    = (cur.size() != 0);
            v[1]    = m_msg0;
            v[12:8] = m_idx[4:0];
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   always @(negedge clk) begin
      logic        exp_rdy, acc, rise, clr;
      logic [31:0] le, sig;
      if (rst) begin
         chk("rst_rdy", {31'd0, rx_pkt_rdy}, 32'd0);
         chk("rst_ack", {31'd0, cbus_ack}, 32'd0);
         chk("rst_rdata", cbus_rdata, 32'd0);
         chk("rst_dbg", dbg_sig, 32'd0);
         m_pkt = 0; m_beats = 0; m_runt = 0; m_last_sig = 0; m_idle = 0;
         m_msg0 = 0; m_req_d = 0; m_ack_exp = 0; m_rd_exp = 0; m_idx = 0;
         cur.delete();
      end else begin
         exp_rdy = cfg_mon_en && cfg_rdy_pat[m_idx];
         chk("rdy", {31'd0, rx_pkt_rdy}, {31'd0, exp_rdy});
         chk("ack", {31'd0, cbus_ack}, {31'd0, m_ack_exp});
         if (m_ack_exp) chk("rdata", cbus_rdata, m_rd_exp);
         rise = cbus_req && !m_req_d;
         m_ack_exp = rise;
         if (rise && !cbus_rw) m_rd_exp = m_read(cbus_addr);
         clr = rise && cbus_rw && cbus_addr == 16'd5 && cbus_wdata[0];
         acc = rx_pkt_vld && exp_rdy;
         le  = (cfg_pkt_len == 0) ? 32'd1 : cfg_pkt_len;
         if (!cfg_mon_en) begin
            cur.delete();
            m_idle = 0;
         end else if (acc) begin
            m_beats = sinc(m_beats);
            cur.push_back(fold_m(rx_pkt_dat));
            m_idle = 0;
            if (32'(cur.size()) >= le) begin
               sig = '0;
               foreach (cur[i]) sig ^= cur[i];
               m_pkt = sinc(m_pkt);
               m_last_sig = sig;
               m_msg0 = rx_pkt_msg[0];
               cur.delete();
            end
         end else if (cur.size() != 0) begin
            m_idle = sinc(m_idle);
            if (cfg_timeout != 0 && m_idle == cfg_timeout) begin
               m_runt = sinc(m_runt);
               cur.delete();
               m_idle = 0;
            end
         end
         if (clr) begin
            m_pkt = 0; m_beats = 0; m_runt = 0; m_last_sig = 0;
         end
         m_req_d = cbus_req;
         m_idx = cfg_mon_en ? (m_idx + 1) % 32 : 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic logic [255:0] rnd_dat();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic send_beat(input logic [255:0] d);
      bit ok;
      ok = 0;
      rx_pkt_dat = d;
      rx_pkt_msg = 20'($urandom());
      rx_pkt_vld = 1'b1;
      for (int n = 0; n < 64 && !ok; n++) begin
         @(negedge clk);
         if (rx_pkt_rdy) ok = 1;
         @(posedge clk); #1;
      end
      rx_pkt_vld = 1'b0;
      if (!ok) chk("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_pkt(input int n);
      for (int i = 0; i < n; i++) send_beat(rnd_dat());
   endtask

   task automatic cbus_xfer(input logic rw, input logic [15:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
      bit got;
      got = 0;
      rd = '0;
      cbus_req = 1'b1; cbus_rw = rw; cbus_addr = a; cbus_wdata = wd;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk);
         if (cbus_ack) begin got = 1; rd = cbus_rdata; end
         @(posedge clk); #1;
      end
      cbus_req = 1'b0;
      if (!got) chk("cbus_timeout", 32'd0, 32'd1);
      idle(1);
   endtask

   task automatic rd_chk(input string nm, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] v;
      cbus_xfer(1'b0, a, 32'd0, v);
      chk(nm, v, exp);
   endtask

   task automatic setup(input logic [31:0] len, input logic [31:0] pat, input logic [31:0] to);
      logic [31:0] v;
      cfg_mon_en = 1'b0;
      idle(2);
      cfg_pkt_len = len; cfg_rdy_pat = pat; cfg_timeout = to;
      cfg_mon_en = 1'b1;
      cbus_xfer(1'b1, 16'd5, 32'd1, v);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] v;
      logic        prev;
      rst = 1'b0;
      rx_pkt_vld = 0; rx_pkt_dat = '0; rx_pkt_msg = '0;
      cfg_pkt_len = 4; cfg_rdy_pat = '1; cfg_timeout = 0; cfg_mon_en = 0;
      cbus_req = 0; cbus_rw = 0; cbus_addr = '0; cbus_wdata = '0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(1);
      rd_chk("init_pkt", 16'd0, 32'd0);
      rd_chk("init_sig", 16'd3, 32'd0);

      // three 4-beat packets at full rate
      setup(4, 32'hFFFF_FFFF, 0);
      send_pkt(12);
      idle(1);
      chk("model_pkt3", m_pkt, 32'd3);
      rd_chk("pkt_cnt3", 16'd0, 32'd3);
      rd_chk("beat_tot12", 16'd1, 32'd12);
      rd_chk("runt0", 16'd2, 32'd0);
      rd_chk("unmapped", 16'd7, 32'd0);

      // signature: first beat folds to zero
      send_beat({8{32'h1}});
      send_beat(256'h2);
      send_beat(256'h4);
      send_beat(256'h8);
      idle(1);
      chk("model_sig", m_last_sig, 32'h0000_000E);
      rd_chk("last_sig", 16'd3, 32'h0000_000E);
      cbus_xfer(1'b1, 16'd3, 32'hDEAD_BEEF, v);
      rd_chk("sig_ro", 16'd3, 32'h0000_000E);

      // alternating ready with valid held high
      setup(4, 32'h5555_5555, 0);
      rx_pkt_dat = rnd_dat();
      rx_pkt_vld = 1'b1;
      prev = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (n > 0) chk("rdy_toggle", {31'd0, rx_pkt_rdy}, {31'd0, ~prev});
         prev = rx_pkt_rdy;
         @(posedge clk); #1;
      end
      rx_pkt_vld = 1'b0;
      rd_chk("alt_beats", 16'd1, 32'd10);
      rd_chk("alt_pkts", 16'd0, 32'd2);

      // runt detection
      setup(4, 32'hFFFF_FFFF, 5);
      send_pkt(2);
      idle(8);
      rd_chk("runt1", 16'd2, 32'd1);
      cbus_xfer(1'b0, 16'd4, 32'd0, v);
      chk("runt_idle", v & 32'd1, 32'd0);
      send_pkt(4);
      rd_chk("runt_pkt1", 16'd0, 32'd1);

      // clear coinciding with EOP
      setup(4, 32'hFFFF_FFFF, 0);
      send_pkt(4);
      send_pkt(3);
      rx_pkt_dat = rnd_dat(); rx_pkt_vld = 1'b1;
      cbus_req = 1'b1; cbus_rw = 1'b1; cbus_addr = 16'd5; cbus_wdata = 32'd1;
      @(negedge clk);
      chk("eop_rdy", {31'd0, rx_pkt_rdy}, 32'd1);
      @(posedge clk); #1;
      rx_pkt_vld = 1'b0;
      @(negedge clk);
      chk("clr_ack", {31'd0, cbus_ack}, 32'd1);
      @(posedge clk); #1;
      cbus_req = 1'b0;
      idle(1);
      chk("model_clr", m_pkt, 32'd0);
      rd_chk("clr_pkt", 16'd0, 32'd0);
      rd_chk("clr_beats", 16'd1, 32'd0);
      rd_chk("clr_runt", 16'd2, 32'd0);
      rd_chk("clr_sig", 16'd3, 32'd0);

      // reset mid-packet
      send_pkt(2);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      send_pkt(4);
      rd_chk("rst_pkt1", 16'd0, 32'd1);
      rd_chk("rst_beats4", 16'd1, 32'd4);

      // random traffic, config changes and cbus activity
      for (int c = 0; c < 2500; c++) begin
         if (c % 150 == 0) begin
            cfg_pkt_len = $urandom_range(0, 5);
            cfg_timeout = $urandom_range(0, 6);
            cfg_rdy_pat = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom();
         end
         if ($urandom_range(0, 60) == 0) cfg_mon_en = ~cfg_mon_en;
         rx_pkt_vld = ($urandom_range(0, 3) != 0);
         rx_pkt_dat = rnd_dat();
         rx_pkt_msg = 20'($urandom());
         cbus_req   = ($urandom_range(0, 3) == 0);
         cbus_rw    = 1'($urandom_range(0, 1));
         cbus_addr  = 16'($urandom_range(0, 7));
         cbus_wdata = $urandom();
         @(posedge clk); #1;
      end
      rx_pkt_vld = 1'b0; cbus_req = 1'b0; cfg_mon_en = 1'b1;
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
